mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage. It consumes the 103-bit execute→memory bus and the data SRAM read data.
- It extracts and extends load data (byte, halfword or word), selects the final writeback result, and produces the memory→writeback bus.
- It exports a forwarding/hazard bus to decode.
- It keeps valid/allowin handshakes on both sides. A hold register protects load data across writeback backpressure, because the SRAM output is only valid for one cycle.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_load_extend.sv | 39 +++
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory pipeline stage: bus widths,
// load opcodes, forwarding-bus field offsets and the load-type decode.
package mem_stage_pkg;

    localparam int BUS_IN_W  = 103;
    localparam int BUS_OUT_W = 102;
    localparam int FWD_W     = 39;

    localparam logic [9:0] LD_B  = 10'h0A0;
    localparam logic [9:0] LD_H  = 10'h0A1;
    localparam logic [9:0] LD_W  = 10'h0A2;
    localparam logic [9:0] LD_BU = 10'h0A8;
    localparam logic [9:0] LD_HU = 10'h0A9;

    localparam int FWD_WE_BIT   = 38;
    localparam int FWD_LOAD_BIT = 37;
    localparam int FWD_DEST_LSB = 32;
    localparam int FWD_RES_LSB  = 0;

    typedef enum logic [2:0] {
        LT_B,
        LT_H,
        LT_W,
        LT_BU,
        LT_HU
    } load_type_e;

    // Unrecognised opcodes fall back to a full-word load.
    function automatic load_type_e decode_load(input logic [9:0] op);
        case (op)
            LD_B:    return LT_B;
            LD_H:    return LT_H;
            LD_W:    return LT_W;
            LD_BU:   return LT_BU;
            LD_HU:   return LT_HU;
            default: return LT_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Byte/halfword/word extraction from the SRAM read word with sign or zero
// extension according to the decoded load type.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  load_type_e  ltype,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword alignment is enforced upstream, so only bit 1 matters.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (ltype)
            LT_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LT_H:    result = {{16{half_sel[15]}}, half_sel};
            LT_BU:   result = {24'd0, byte_sel};
            LT_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute->memory bus, extends load data,
// builds the writeback bus and the decode forwarding bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 exe_mem_valid,
    output logic                 mem_allowin,
    input  logic [BUS_IN_W-1:0]  exe_mem_bus,
    input  logic                 wb_allowin,
    output logic                 mem_wb_valid,
    output logic [BUS_OUT_W-1:0] mem_wb_bus,
    input  logic [31:0]          data_sram_rdata,
    output logic [FWD_W-1:0]     mem_fwd_bus
);

    logic                mem_valid_q, mem_valid_d;
    logic                rdata_held_q, rdata_held_d;
    logic [31:0]         hold_q, hold_d;
    logic [BUS_IN_W-1:0] payload_q, payload_d;

    logic        ready_go;
    logic        in_fire;
    logic        gr_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [31:0] eff_rdata;
    logic [31:0] load_data;
    logic [31:0] final_result;
    load_type_e  ltype;

    assign ready_go     = 1'b1;
    assign mem_allowin  = ~mem_valid_q | (ready_go & wb_allowin);
    assign mem_wb_valid = mem_valid_q & ready_go;
    assign in_fire      = exe_mem_valid & mem_allowin;

    assign gr_we        = payload_q[102];
    assign res_from_mem = payload_q[101];
    assign dest         = payload_q[100:96];
    assign pc           = payload_q[95:64];
    assign inst         = payload_q[63:32];
    assign alu_result   = payload_q[31:0];

    always_comb begin
        mem_valid_d  = mem_allowin ? exe_mem_valid : mem_valid_q;
        payload_d    = in_fire ? exe_mem_bus : payload_q;
        rdata_held_d = rdata_held_q;
        hold_d       = hold_q;
        // SRAM data lasts one cycle; capture it the first time writeback stalls.
        if (mem_valid_q & ~rdata_held_q & ~wb_allowin) begin
            rdata_held_d = 1'b1;
            hold_d       = data_sram_rdata;
        end else if (in_fire | ~mem_valid_d) begin
            rdata_held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            rdata_held_q <= 1'b0;
            hold_q       <= 32'd0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            rdata_held_q <= rdata_held_d;
            hold_q       <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign eff_rdata = rdata_held_q ? hold_q : data_sram_rdata;
    assign ltype     = decode_load(inst[31:22]);

    load_extend u_load_extend (
        .rdata   (eff_rdata),
        .addr_lo (alu_result[1:0]),
        .ltype   (ltype),
        .result  (load_data)
    );

    assign final_result = res_from_mem ? load_data : alu_result;
    assign mem_wb_bus   = {gr_we, dest, pc, inst, final_result};

    always_comb begin
        mem_fwd_bus                         = '0;
        mem_fwd_bus[FWD_WE_BIT]             = mem_valid_q & gr_we & (dest != 5'd0);
        mem_fwd_bus[FWD_LOAD_BIT]           = mem_valid_q & res_from_mem;
        mem_fwd_bus[FWD_DEST_LSB +: 5]      = dest;
        mem_fwd_bus[FWD_RES_LSB +: 32]      = final_result;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases plus randomized traffic
// checked against a one-deep behavioural model of the stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         exe_mem_valid;
    logic         mem_allowin;
    logic [102:0] exe_mem_bus;
    logic         wb_allowin;
    logic         mem_wb_valid;
    logic [101:0] mem_wb_bus;
    logic [31:0]  data_sram_rdata;
    logic [38:0]  mem_fwd_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .exe_mem_valid   (exe_mem_valid),
        .mem_allowin     (mem_allowin),
        .exe_mem_bus     (exe_mem_bus),
        .wb_allowin      (wb_allowin),
        .mem_wb_valid    (mem_wb_valid),
        .mem_wb_bus      (mem_wb_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_fwd_bus     (mem_fwd_bus)
    );

    typedef struct {
        logic [101:0] wb;
        logic [38:0]  fwd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [102:0] mk_bus(input bit gr_we, input bit rfm, input logic [4:0] dest,
                                            input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [31:0] alu);
        return {gr_we, rfm, dest, pc, inst, alu};
    endfunction

    // Reference: pick the addressed byte/half arithmetically and extend it.
    function automatic logic [31:0] ref_result(input logic [102:0] bus, input logic [31:0] rd);
        logic [9:0]  op;
        logic [31:0] alu;
        int          off;
        int          b;
        int          h;
        op  = bus[63:54];
        alu = bus[31:0];
        off = int'(alu[1:0]);
        b   = int'((rd >> (8 * off)) & 32'hFF);
        h   = int'((rd >> (alu[1] ? 16 : 0)) & 32'hFFFF);
        if (!bus[101]) return alu;
        case (op)
            10'h0A0: return 32'(b >= 128 ? b - 256 : b);
            10'h0A1: return 32'(h >= 32768 ? h - 65536 : h);
            10'h0A8: return 32'(b);
            10'h0A9: return 32'(h);
            default: return rd;
        endcase
    endfunction

    // One clock of stimulus; the stage is one deep, so an offered instruction
    // is taken exactly when the model holds nothing after this cycle's transfer.
    task automatic step(input bit v, input logic [102:0] bus, input logic [31:0] ld_rd,
                        input bit wb_a, input logic [31:0] idle_rd);
        exp_t        e;
        logic [31:0] r;
        exe_mem_valid = v;
        exe_mem_bus   = bus;
        wb_allowin    = wb_a;
        @(posedge clk);
        #1;
        if (v && q.size() == 0) begin
            r     = ref_result(bus, ld_rd);
            e.wb  = {bus[102], bus[100:96], bus[95:64], bus[63:32], r};
            e.fwd = {bus[102] && (bus[100:96] != 5'd0), bus[101], bus[100:96], r};
            q.push_back(e);
            data_sram_rdata = ld_rd;
        end else begin
            data_sram_rdata = idle_rd;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_wb_valid", 128'(mem_wb_valid), 128'(q.size() != 0));
            chk("mem_allowin", 128'(mem_allowin), 128'(q.size() == 0 || wb_allowin));
            if (q.size() != 0) begin
                chk("mem_wb_bus", 128'(mem_wb_bus), 128'(q[0].wb));
                chk("mem_fwd_bus", 128'(mem_fwd_bus), 128'(q[0].fwd));
                if (wb_allowin) void'(q.pop_front());
            end else begin
                chk("fwd_idle", 128'(mem_fwd_bus[38:37]), 128'(2'b00));
            end
        end
    end

    function automatic logic [102:0] rand_bus();
        logic [9:0] ops[5];
        logic [9:0] op;
        logic [4:0] dest;
        int         kind;
        bit         rfm;
        ops[0] = 10'h0A0; ops[1] = 10'h0A1; ops[2] = 10'h0A2; ops[3] = 10'h0A8; ops[4] = 10'h0A9;
        kind = int'($urandom_range(0, 6));
        if (kind < 5) begin
            op  = ops[kind];
            rfm = 1'b1;
        end else begin
            op  = 10'($urandom);
            rfm = (kind == 5);
        end
        dest = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return mk_bus(1'($urandom), rfm, dest, $urandom, {op, 22'($urandom)}, $urandom);
    endfunction

    initial begin
        resetn          = 1'b0;
        exe_mem_valid   = 1'b0;
        wb_allowin      = 1'b0;
        exe_mem_bus     = '0;
        data_sram_rdata = 32'd0;
        #2;
        chk("rst_valid", 128'(mem_wb_valid), 128'(0));
        chk("rst_allowin", 128'(mem_allowin), 128'(1));
        chk("rst_fwd_we", 128'(mem_fwd_bus[38]), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_en = 1'b1;

        // ld.b at offset 1, then a single idle cycle.
        step(1, mk_bus(1, 1, 5'd3, 32'h100, {10'h0A0, 22'h0}, 32'h1000_0001), 32'h1234_80FF, 1, $urandom);
        step(0, '0, 0, 1, $urandom);
        // ld.hu then ld.h at offset 2.
        step(1, mk_bus(1, 1, 5'd4, 32'h104, {10'h0A9, 22'h5}, 32'h1000_0002), 32'h9ABC_0001, 1, $urandom);
        step(1, mk_bus(1, 1, 5'd5, 32'h108, {10'h0A1, 22'h5}, 32'h1000_0002), 32'h9ABC_0001, 1, $urandom);
        step(0, '0, 0, 1, $urandom);
        // ld.w held across a three-cycle writeback stall while SRAM goes to zero.
        step(1, mk_bus(1, 1, 5'd6, 32'h10C, {10'h0A2, 22'h0}, 32'h1000_0000), 32'hDEAD_BEEF, 1, 32'd0);
        repeat (3) step(0, '0, 0, 0, 32'd0);
        step(0, '0, 0, 1, 32'd0);
        step(0, '0, 0, 1, 32'd0);
        // add then ld.w back to back.
        step(1, mk_bus(1, 0, 5'd7, 32'h110, 32'h0010_0000, 32'h11), 32'h0, 1, $urandom);
        step(1, mk_bus(1, 1, 5'd8, 32'h114, {10'h0A2, 22'h0}, 32'h2000_0000), 32'h22, 1, $urandom);
        step(0, '0, 0, 1, $urandom);
        step(0, '0, 0, 1, $urandom);
        // Register write to r0 must not forward.
        step(1, mk_bus(1, 0, 5'd0, 32'h118, 32'h0010_0000, 32'h33), 32'h0, 1, $urandom);
        step(0, '0, 0, 1, $urandom);

        // Reset in the middle of a stall.
        step(1, mk_bus(1, 1, 5'd9, 32'h11C, {10'h0A2, 22'h0}, 32'h3000_0000), 32'hCAFE_F00D, 1, 32'd0);
        step(0, '0, 0, 0, 32'd0);
        step(0, '0, 0, 0, 32'd0);
        #2;
        chk_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(mem_wb_valid), 128'(0));
        chk("rst_mid_fwd_we", 128'(mem_fwd_bus[38]), 128'(0));
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        chk("rst_rel_allowin", 128'(mem_allowin), 128'(1));
        chk_en = 1'b1;

        repeat (400) begin
            step(($urandom_range(0, 3) != 0), rand_bus(), $urandom,
                 ($urandom_range(0, 2) != 0), $urandom);
        end
        repeat (3) step(0, '0, 0, 1, $urandom);
        chk("drain", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
